apu_frame_sequencer: RTL and testbench
======================================

# apu_frame_sequencer

Frame sequencer for the APU audio path: counts CPU-rate clock enables and emits the quarter-frame and half-frame strobes that clock the envelope units and the length counters. It also owns the frame IRQ. It sits between the CPU register write/read decode for $4017/$4015 and every channel's `lengthCounter`, whose `clk` enable it drives.

## Interface
- `STEP1`, default 7457: cycle count of the first quarter-frame event.
- `STEP2`, default 14913: cycle count of the second (quarter + half) event.
- `STEP3`, default 22371: cycle count of the third (quarter) event.
- `STEP4`, default 29829: cycle count of the final 4-step event (quarter + half + IRQ); ignored in 5-step mode.
- `STEP5`, default 37281: cycle count of the final 5-step event (quarter + half).
- `WR_DELAY`, default 3: number of `ce` cycles from a $4017 write to the counter reset.
- `clk  in  1`: system clock.
- `rst_n  in  1`: asynchronous active-low reset.
- `ce  in  1`: CPU-cycle enable; the counter advances only when it is high.
- `wr_en  in  1`: one-cycle write strobe for $4017.
- `wr_data  in  2`: `[1]` = mode (1 = 5-step), `[0]` = IRQ inhibit.
- `irq_clr  in  1`: one-cycle strobe for a $4015 read; clears `frame_irq`.
- `quarter_frame  out  1`: one-`clk` pulse that clocks the envelopes and linear counter.
- `half_frame  out  1`: one-`clk` pulse that clocks the length counters and sweeps.
- `frame_irq  out  1`: level; frame interrupt flag.
- `step  out  3`: index of the last event fired, 0–5 (debug).

## Operation
- The registers are `cnt[15:0]`, `mode`, `inhibit`, `pend_cnt[1:0]` and `state`.
- There are two states, `RUN` and `PEND`.
  - In `RUN`, on each `ce` cycle `cnt` increments, and compares are made against `cnt` before the increment.
  - Events:
    - `cnt == STEP1` or `cnt == STEP3`: quarter.
    - `cnt == STEP2`: quarter + half.
    - In 4-step mode, `cnt == STEP4`: quarter + half; set `frame_irq` if `!inhibit`; `cnt` <= 0.
    - In 5-step mode, `cnt == STEP4` does nothing. `cnt == STEP5`: quarter + half; `cnt` <= 0.
- When `wr_en` is high:
  - `mode` and `inhibit` latch immediately.
  - If `wr_data[0]` = 1, `frame_irq` clears.
  - `pend_cnt` <= `WR_DELAY` − 1 and `state` <= `PEND`.
  - If `wr_data[1]` = 1, quarter + half fire the next cycle. This happens regardless of pending.
- In `PEND`, `cnt` keeps counting and firing events as in `RUN`, and `pend_cnt` decrements on each `ce`. On the `ce` cycle where `pend_cnt == 0`, `cnt` <= 0 and `state` <= `RUN`. That counter reset overrides any event reset in the same cycle. The event itself still fires.
- A new `wr_en` while in `PEND` restarts the delay with the new data.
- `irq_clr` clears `frame_irq`. If `irq_clr` and an IRQ set occur in the same cycle, the set wins.
- `step` updates to 1–5 on each event and wraps to 0 on reset.

## Timing
- Reset values: `cnt` = 0, `mode` = 0, `inhibit` = 0, `state` = `RUN`, `quarter_frame` = 0, `half_frame` = 0, `frame_irq` = 0, `step` = 0.
- All outputs are registered. A strobe is high for exactly one `clk`, namely the cycle after the `ce` edge on which the compare matched.
- Strobes never last longer than one cycle, even if `ce` is held high continuously.
- `frame_irq` rises one `clk` after the `STEP4` match edge.
- With `ce` tied high, a full 4-step period is `STEP4` + 1 `ce` cycles and a full 5-step period is `STEP5` + 1.
- If `rst_n` falls mid-period, all state clears asynchronously and no strobe is emitted on release.

## Structure
- Shared package `apu_pkg`:
  - default step constants `STEP1`–`STEP5`;
  - mode encodings `MODE_4STEP` = 0 and `MODE_5STEP` = 1;
  - the state enum `RUN`/`PEND`.
- One sub-module, `frame_step_decode`. It is combinational: from `cnt` and `mode` it produces `is_quarter`, `is_half`, `is_irq`, `is_wrap` and `step_idx`.

## Test plan
- Reset, then `ce` = 1 in 4-step mode: quarter pulses at `cnt` 7457, 14913, 22371 and 29829; half pulses at 14913 and 29829; `frame_irq` = 1 after 29829; `cnt` returns to 0.
- Write `wr_data` = 2'b10: quarter + half fire on the next cycle; `cnt` = 0 after 3 `ce`; no IRQ across 37281; the final event is at 37281.
- Write `wr_data` = 2'b01 while `frame_irq` = 1: `frame_irq` = 0 next cycle and stays 0 through the following `STEP4`.
- `irq_clr` on the same cycle as the `STEP4` IRQ set: `frame_irq` = 1. `irq_clr` one cycle later: `frame_irq` = 0.
- Hold `ce` low for 5 `clk` around `STEP2`: no strobe until the `ce` edge at `cnt` 14913; then exactly one pulse on each of `quarter_frame` and `half_frame`.
- Drive `half_frame` into a `lengthCounter` loaded with 5'b10100 and `halt` = 0: `out` decrements once per half-frame. Assert `rst_n` = 0 mid-frame: all outputs are 0 immediately.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared constants and types for the APU frame sequencer.
package apu_pkg;

    // Default event positions, in CPU-cycle enables from the start of a frame.
    localparam logic [15:0] STEP1_DEF = 16'd7457;
    localparam logic [15:0] STEP2_DEF = 16'd14913;
    localparam logic [15:0] STEP3_DEF = 16'd22371;
    localparam logic [15:0] STEP4_DEF = 16'd29829;
    localparam logic [15:0] STEP5_DEF = 16'd37281;

    // Sequencer mode, as written to bit 1 of $4017.
    localparam logic MODE_4STEP = 1'b0;
    localparam logic MODE_5STEP = 1'b1;

    // RUN counts normally; PEND also counts down the $4017 write delay.
    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fs_state_e;

endpackage

// File: rtl/frame_step_decode.sv
// Combinational event decode: which strobes a given count value fires.
module frame_step_decode
    import apu_pkg::*;
#(
    parameter logic [15:0] STEP1 = STEP1_DEF,
    parameter logic [15:0] STEP2 = STEP2_DEF,
    parameter logic [15:0] STEP3 = STEP3_DEF,
    parameter logic [15:0] STEP4 = STEP4_DEF,
    parameter logic [15:0] STEP5 = STEP5_DEF
) (
    input  logic [15:0] i_cnt,
    input  logic        i_mode,
    output logic        o_is_quarter,
    output logic        o_is_half,
    output logic        o_is_irq,
    output logic        o_is_wrap,
    output logic [2:0]  o_step_idx
);

    // Match the pre-increment count; STEP4 only matters in 4-step mode, STEP5 only in 5-step mode.
    always_comb begin
        o_is_quarter = 1'b0;
        o_is_half    = 1'b0;
        o_is_irq     = 1'b0;
        o_is_wrap    = 1'b0;
        o_step_idx   = 3'd0;
        if (i_cnt == STEP1) begin
            o_is_quarter = 1'b1;
            o_step_idx   = 3'd1;
        end else if (i_cnt == STEP2) begin
            o_is_quarter = 1'b1;
            o_is_half    = 1'b1;
            o_step_idx   = 3'd2;
        end else if (i_cnt == STEP3) begin
            o_is_quarter = 1'b1;
            o_step_idx   = 3'd3;
        end else if ((i_cnt == STEP4) && (i_mode == MODE_4STEP)) begin
            o_is_quarter = 1'b1;
            o_is_half    = 1'b1;
            o_is_irq     = 1'b1;
            o_is_wrap    = 1'b1;
            o_step_idx   = 3'd4;
        end else if ((i_cnt == STEP5) && (i_mode == MODE_5STEP)) begin
            o_is_quarter = 1'b1;
            o_is_half    = 1'b1;
            o_is_wrap    = 1'b1;
            o_step_idx   = 3'd5;
        end
    end

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: quarter/half-frame strobes, frame IRQ and the $4017 write delay.
// Handshake: wr_en and irq_clr are single-cycle strobes with no back-pressure;
// quarter_frame/half_frame are single-cycle registered pulses, frame_irq is a level.
module apu_frame_sequencer
    import apu_pkg::*;
#(
    parameter logic [15:0] STEP1    = STEP1_DEF,
    parameter logic [15:0] STEP2    = STEP2_DEF,
    parameter logic [15:0] STEP3    = STEP3_DEF,
    parameter logic [15:0] STEP4    = STEP4_DEF,
    parameter logic [15:0] STEP5    = STEP5_DEF,
    parameter int unsigned WR_DELAY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       wr_en,
    input  logic [1:0] wr_data,
    input  logic       irq_clr,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic [2:0] step,
    output logic       dbg_state
);

    localparam logic [1:0] PEND_INIT = 2'(WR_DELAY - 1);

    logic [15:0] r_cnt;
    logic        r_mode;
    logic        r_inhibit;
    logic [1:0]  r_pend_cnt;
    fs_state_e   r_state;
    logic        r_quarter;
    logic        r_half;
    logic        r_irq;
    logic [2:0]  r_step;

    logic        w_is_quarter;
    logic        w_is_half;
    logic        w_is_irq;
    logic        w_is_wrap;
    logic [2:0]  w_step_idx;

    frame_step_decode #(
        .STEP1 (STEP1),
        .STEP2 (STEP2),
        .STEP3 (STEP3),
        .STEP4 (STEP4),
        .STEP5 (STEP5)
    ) u_decode (
        .i_cnt        (r_cnt),
        .i_mode       (r_mode),
        .o_is_quarter (w_is_quarter),
        .o_is_half    (w_is_half),
        .o_is_irq     (w_is_irq),
        .o_is_wrap    (w_is_wrap),
        .o_step_idx   (w_step_idx)
    );

    // Counter, mode latch and write-delay FSM; the delayed reset beats an event wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 16'd0;
            r_mode     <= MODE_4STEP;
            r_inhibit  <= 1'b0;
            r_pend_cnt <= 2'd0;
            r_state    <= RUN;
        end else begin
            if (ce) begin
                if (w_is_wrap) begin
                    r_cnt <= 16'd0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
                if (r_state == PEND) begin
                    if (r_pend_cnt == 2'd0) begin
                        r_cnt   <= 16'd0;
                        r_state <= RUN;
                    end else begin
                        r_pend_cnt <= r_pend_cnt - 2'd1;
                    end
                end
            end
            if (wr_en) begin
                r_mode     <= wr_data[1];
                r_inhibit  <= wr_data[0];
                r_pend_cnt <= PEND_INIT;
                r_state    <= PEND;
            end
        end
    end

    // Registered strobes and step index; a 5-step write clocks quarter+half at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quarter <= 1'b0;
            r_half    <= 1'b0;
            r_step    <= 3'd0;
        end else begin
            r_quarter <= (ce & w_is_quarter) | (wr_en & wr_data[1]);
            r_half    <= (ce & w_is_half) | (wr_en & wr_data[1]);
            if (ce && (w_is_quarter || w_is_half)) begin
                r_step <= w_step_idx;
            end
        end
    end

    // Frame IRQ flag: a set on the STEP4 event wins over any clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else if (ce && w_is_irq && !r_inhibit) begin
            r_irq <= 1'b1;
        end else if (irq_clr || (wr_en && wr_data[0])) begin
            r_irq <= 1'b0;
        end
    end

    assign quarter_frame = r_quarter;
    assign half_frame    = r_half;
    assign frame_irq     = r_irq;
    assign step          = r_step;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer, built with short step positions
// (10/20/30/40/50) so whole 4-step and 5-step frames fit in a short run.
module tb_apu_frame_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       ce;
    logic       wr_en;
    logic [1:0] wr_data;
    logic       irq_clr;
    logic       quarter_frame;
    logic       half_frame;
    logic       frame_irq;
    logic [2:0] step;
    logic       dbg_state;

    apu_frame_sequencer #(
        .STEP1    (16'd10),
        .STEP2    (16'd20),
        .STEP3    (16'd30),
        .STEP4    (16'd40),
        .STEP5    (16'd50),
        .WR_DELAY (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ce            (ce),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .irq_clr       (irq_clr),
        .quarter_frame (quarter_frame),
        .half_frame    (half_frame),
        .frame_irq     (frame_irq),
        .step          (step),
        .dbg_state     (dbg_state)
    );

    // Downstream length counter clocked by half_frame.
    logic [4:0] lc;
    logic       lc_load;
    logic       lc_halt;
    always_ff @(posedge clk) begin
        if (lc_load) lc <= 5'b10100;
        else if (half_frame && !lc_halt && (lc != 5'd0)) lc <= lc - 5'd1;
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [4:0] exp_q[$];
    logic [4:0] sb_exp;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every strobe cycle pops one expected {quarter, half, step} entry.
    always @(negedge clk) begin
        if (quarter_frame || half_frame) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra", {3'd0, quarter_frame, half_frame, step}, 8'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_event", {3'd0, quarter_frame, half_frame, step}, {3'd0, sb_exp});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            chk("quiet_q", quarter_frame, 1'b0);
            chk("quiet_h", half_frame, 1'b0);
        end
    endtask

    task automatic fire(input int n_quiet, input logic exp_h, input logic [2:0] exp_step);
        exp_q.push_back({1'b1, exp_h, exp_step});
        quiet(n_quiet);
        tick(1);
        chk("fire_q", quarter_frame, 1'b1);
        chk("fire_h", half_frame, exp_h);
    endtask

    task automatic write4017(input logic [1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick(1);
        wr_en   = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0; ce = 1'b0; wr_en = 1'b0; wr_data = 2'b00; irq_clr = 1'b0;
        lc_load = 1'b0; lc_halt = 1'b0;

        // Reset state and clean release.
        tick(2);
        chk("rst_q", quarter_frame, 1'b0);
        chk("rst_h", half_frame, 1'b0);
        chk("rst_irq", frame_irq, 1'b0);
        chk("rst_step", step, 3'd0);
        chk("rst_state", dbg_state, 1'b0);
        rst_n = 1'b1;
        quiet(2);

        // 4-step frame with ce held high: events at edges 11/21/31/41, wrap, next at 52.
        exp_q.push_back(5'b10_001);
        exp_q.push_back(5'b11_010);
        exp_q.push_back(5'b10_011);
        exp_q.push_back(5'b11_100);
        exp_q.push_back(5'b10_001);
        ce = 1'b1;
        for (int e = 1; e <= 52; e++) begin
            tick(1);
            chk("b_quarter", quarter_frame, (e == 11) || (e == 21) || (e == 31) || (e == 41) || (e == 52));
            chk("b_half", half_frame, (e == 21) || (e == 41));
            chk("b_irq", frame_irq, e >= 41);
        end
        chk("b_step", step, 3'd1);

        // irq_clr alone clears the flag.
        irq_clr = 1'b1;
        tick(1);
        irq_clr = 1'b0;
        chk("clr_irq", frame_irq, 1'b0);

        // 5-step write: immediate quarter+half, counter restarts after 3 ce.
        exp_q.push_back(5'b11_001);
        write4017(2'b10);
        chk("w5_q", quarter_frame, 1'b1);
        chk("w5_h", half_frame, 1'b1);
        fire(13, 1'b0, 3'd1);
        fire(9, 1'b1, 3'd2);
        fire(9, 1'b0, 3'd3);
        fire(19, 1'b1, 3'd5);
        chk("w5_noirq", frame_irq, 1'b0);
        chk("w5_step", step, 3'd5);
        fire(10, 1'b0, 3'd1);

        // Back to 4-step without inhibit: IRQ sets at STEP4.
        write4017(2'b00);
        chk("w4_noq", quarter_frame, 1'b0);
        fire(13, 1'b0, 3'd1);
        fire(9, 1'b1, 3'd2);
        fire(9, 1'b0, 3'd3);
        fire(9, 1'b1, 3'd4);
        chk("w4_irq", frame_irq, 1'b1);
        chk("w4_step", step, 3'd4);

        // Inhibit write clears the flag and blocks the next STEP4 set.
        write4017(2'b01);
        chk("inh_clr", frame_irq, 1'b0);
        fire(13, 1'b0, 3'd1);
        fire(9, 1'b1, 3'd2);
        fire(9, 1'b0, 3'd3);
        fire(9, 1'b1, 3'd4);
        chk("inh_noirq", frame_irq, 1'b0);

        // irq_clr coinciding with the STEP4 set: set wins; one cycle later it clears.
        write4017(2'b00);
        fire(13, 1'b0, 3'd1);
        fire(9, 1'b1, 3'd2);
        fire(9, 1'b0, 3'd3);
        exp_q.push_back(5'b11_100);
        quiet(9);
        irq_clr = 1'b1;
        tick(1);
        chk("race_q", quarter_frame, 1'b1);
        chk("race_h", half_frame, 1'b1);
        chk("race_irq", frame_irq, 1'b1);
        tick(1);
        irq_clr = 1'b0;
        chk("race_clr", frame_irq, 1'b0);

        // ce stalled just before STEP2: nothing until the ce edge at count 20, then one pulse.
        fire(9, 1'b0, 3'd1);
        quiet(9);
        ce = 1'b0;
        quiet(5);
        ce = 1'b1;
        exp_q.push_back(5'b11_010);
        tick(1);
        chk("stall_q", quarter_frame, 1'b1);
        chk("stall_h", half_frame, 1'b1);
        quiet(3);

        // Length counter follows half_frame.
        lc_load = 1'b1;
        tick(1);
        lc_load = 1'b0;
        chk("lc_load", lc, 5'd20);
        fire(5, 1'b0, 3'd3);
        chk("lc_q_only", lc, 5'd20);
        fire(9, 1'b1, 3'd4);
        fire(10, 1'b0, 3'd1);
        chk("lc_dec1", lc, 5'd19);
        fire(9, 1'b1, 3'd2);
        chk("lc_hold", lc, 5'd19);

        // Asynchronous reset mid-frame with strobes and IRQ high.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_q", quarter_frame, 1'b0);
        chk("arst_h", half_frame, 1'b0);
        chk("arst_irq", frame_irq, 1'b0);
        chk("arst_step", step, 3'd0);
        tick(2);
        rst_n = 1'b1;
        quiet(3);
        chk("rel_step", step, 3'd0);
        chk("rel_irq", frame_irq, 1'b0);
        fire(7, 1'b0, 3'd1);

        @(negedge clk);
        #1;
        chk("sb_drained", 8'(exp_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
